// File: rtl/apb_master_pkg.sv
// Shared definitions for the APB initiator: state encoding and default abort limit.
package apb_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_e;

    localparam int DEF_TIMEOUT = 16;

endpackage

// File: rtl/apb_wait_timer.sv
// Loadable down-counter; expired_o is high once the count has reached zero.
module apb_wait_timer #(
    parameter int W = 5
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         expired_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i)                       cnt_q <= '0;
        else if (load_i)                 cnt_q <= load_val_i;
        else if (dec_i && cnt_q != '0)   cnt_q <= cnt_q - 1'b1;
    end

    assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/apb_master_ctrl.sv
// Single-outstanding APB initiator: command port in, SETUP/ACCESS transfer out,
// one-cycle response strobe back. All outputs are registered.
module apb_master_ctrl
    import apb_master_pkg::*;
#(
    parameter int AWIDTH  = 8,
    parameter int DWIDTH  = 8,
    parameter int NSLOTS  = 4,
    parameter int SWIDTH  = 2,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              CMD_VALID,
    output logic              CMD_READY,
    input  logic              CMD_WRITE,
    input  logic [SWIDTH-1:0] CMD_SLOT,
    input  logic [AWIDTH-1:0] CMD_ADDR,
    input  logic [DWIDTH-1:0] CMD_WDATA,
    output logic              RSP_VALID,
    output logic [DWIDTH-1:0] RSP_RDATA,
    output logic              RSP_ERR,
    output logic              RSP_TIMEOUT,
    output logic [7:0]        ERR_COUNT,
    output logic [NSLOTS-1:0] PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [AWIDTH-1:0] PADDR,
    output logic [DWIDTH-1:0] PWDATA,
    input  logic [DWIDTH-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              bad_slot_q, bad_slot_d;
    logic [NSLOTS-1:0] psel_q, psel_d, slot_onehot;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [AWIDTH-1:0] paddr_q, paddr_d;
    logic [DWIDTH-1:0] pwdata_q, pwdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DWIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic              rsp_to_q, rsp_to_d;
    logic [7:0]        err_cnt_q, err_cnt_d;
    logic              tmr_load, tmr_dec, tmr_expired;

    apb_wait_timer #(.W(TW)) u_timer (
        .clk_i      (PCLK),
        .rst_i      (PRESET),
        .load_i     (tmr_load),
        .load_val_i (TMR_LOAD),
        .dec_i      (tmr_dec),
        .expired_o  (tmr_expired)
    );

    // An out-of-range slot decodes to all zeros, so no slave is ever selected.
    always_comb begin
        slot_onehot = '0;
        for (int i = 0; i < NSLOTS; i++) slot_onehot[i] = (int'(CMD_SLOT) == i);
    end

    always_comb begin
        state_d     = state_q;
        bad_slot_d  = bad_slot_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        rsp_to_d    = rsp_to_q;
        err_cnt_d   = err_cnt_q;
        tmr_load    = 1'b0;
        tmr_dec     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (CMD_VALID && cmd_ready_q) begin
                    pwrite_d   = CMD_WRITE;
                    paddr_d    = CMD_ADDR;
                    pwdata_d   = CMD_WDATA;
                    psel_d     = slot_onehot;
                    bad_slot_d = (int'(CMD_SLOT) >= NSLOTS);
                    state_d    = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (bad_slot_q) begin
                    // Bad slot spends this cycle idle on the bus and reports an error.
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    rsp_to_d    = 1'b0;
                end else begin
                    penable_d = 1'b1;
                    tmr_load  = 1'b1;
                    state_d   = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (PREADY) begin
                    state_d     = ST_IDLE;
                    psel_d      = '0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = pwrite_q ? '0 : PRDATA;
                    rsp_err_d   = PSLVERR;
                    rsp_to_d    = 1'b0;
                end else if (tmr_expired) begin
                    state_d     = ST_IDLE;
                    psel_d      = '0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    rsp_to_d    = 1'b1;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (rsp_valid_d && rsp_err_d && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
        cmd_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b0;
            bad_slot_q  <= 1'b0;
            psel_q      <= '0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            rsp_to_q    <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            bad_slot_q  <= bad_slot_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            rsp_to_q    <= rsp_to_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign CMD_READY   = cmd_ready_q;
    assign RSP_VALID   = rsp_valid_q;
    assign RSP_RDATA   = rsp_rdata_q;
    assign RSP_ERR     = rsp_err_q;
    assign RSP_TIMEOUT = rsp_to_q;
    assign ERR_COUNT   = err_cnt_q;
    assign PSEL        = psel_q;
    assign PENABLE     = penable_q;
    assign PWRITE      = pwrite_q;
    assign PADDR       = paddr_q;
    assign PWDATA      = pwdata_q;

endmodule
